// File: rtl/sha_kt_seq.sv
// sha_kt_seq
//   Multi-channel sequencer for the SHA-2 round constants Kt. Each channel
//   walks t = 0..ROUNDS-1 through a registered constant ROM followed by
//   OUT_REGS output register stages, and presents (kt, kt_t) with kt_valid.
//   The constant image holds the SHA-512 Kt values. The SHA-256 set is the
//   upper 32 bits of the first 64 of them, so KT_WIDTH=32 reads [63:32].
//
// Parameters
//   KT_WIDTH  64 (SHA-512, 80 rounds) or 32 (SHA-256, 64 rounds)
//   N_CH      number of independent channels, 1..4
//   OUT_REGS  output register stages after the ROM read register, 1..3
//
// Ports
//   CLK       clock, rising edge
//   rst       asynchronous active-high reset
//   start     per-channel start request (accepted only in IDLE)
//   hold      per-channel stall, freezes the whole channel
//   clr       per-channel synchronous flush, wins over start and hold
//   busy      channel in RUN or DRAIN
//   kt_valid  kt / kt_t of the channel are valid
//   kt_last   valid word is round ROUNDS-1
//   kt        constant, channel c at [KT_WIDTH*(c+1)-1 : KT_WIDTH*c]
//   kt_t      round index, channel c at [7*(c+1)-1 : 7*c]
module sha_kt_seq #(
    parameter int KT_WIDTH = 64,
    parameter int N_CH     = 2,
    parameter int OUT_REGS = 2
) (
    input  logic                     CLK,
    input  logic                     rst,
    input  logic [N_CH-1:0]          start,
    input  logic [N_CH-1:0]          hold,
    input  logic [N_CH-1:0]          clr,
    output logic [N_CH-1:0]          busy,
    output logic [N_CH-1:0]          kt_valid,
    output logic [N_CH-1:0]          kt_last,
    output logic [N_CH*KT_WIDTH-1:0] kt,
    output logic [N_CH*7-1:0]        kt_t
);

    localparam int         ROUNDS = (KT_WIDTH == 64) ? 80 : 64;
    localparam logic [6:0] LAST_T = 7'(ROUNDS - 1);
    localparam int         N_PAIR = (N_CH + 1) / 2;

    if (KT_WIDTH != 64 && KT_WIDTH != 32) begin : g_bad_kt_width
        $error("sha_kt_seq: KT_WIDTH must be 32 or 64");
    end
    if (N_CH < 1 || N_CH > 4) begin : g_bad_n_ch
        $error("sha_kt_seq: N_CH must be in 1..4");
    end
    if (OUT_REGS < 1 || OUT_REGS > 3) begin : g_bad_out_regs
        $error("sha_kt_seq: OUT_REGS must be in 1..3");
    end

    localparam logic [63:0] K512 [80] = '{
        64'h428a2f98d728ae22, 64'h7137449123ef65cd, 64'hb5c0fbcfec4d3b2f, 64'he9b5dba58189dbbc,
        64'h3956c25bf348b538, 64'h59f111f1b605d019, 64'h923f82a4af194f9b, 64'hab1c5ed5da6d8118,
        64'hd807aa98a3030242, 64'h12835b0145706fbe, 64'h243185be4ee4b28c, 64'h550c7dc3d5ffb4e2,
        64'h72be5d74f27b896f, 64'h80deb1fe3b1696b1, 64'h9bdc06a725c71235, 64'hc19bf174cf692694,
        64'he49b69c19ef14ad2, 64'hefbe4786384f25e3, 64'h0fc19dc68b8cd5b5, 64'h240ca1cc77ac9c65,
        64'h2de92c6f592b0275, 64'h4a7484aa6ea6e483, 64'h5cb0a9dcbd41fbd4, 64'h76f988da831153b5,
        64'h983e5152ee66dfab, 64'ha831c66d2db43210, 64'hb00327c898fb213f, 64'hbf597fc7beef0ee4,
        64'hc6e00bf33da88fc2, 64'hd5a79147930aa725, 64'h06ca6351e003826f, 64'h142929670a0e6e70,
        64'h27b70a8546d22ffc, 64'h2e1b21385c26c926, 64'h4d2c6dfc5ac42aed, 64'h53380d139d95b3df,
        64'h650a73548baf63de, 64'h766a0abb3c77b2a8, 64'h81c2c92e47edaee6, 64'h92722c851482353b,
        64'ha2bfe8a14cf10364, 64'ha81a664bbc423001, 64'hc24b8b70d0f89791, 64'hc76c51a30654be30,
        64'hd192e819d6ef5218, 64'hd69906245565a910, 64'hf40e35855771202a, 64'h106aa07032bbd1b8,
        64'h19a4c116b8d2d0c8, 64'h1e376c085141ab53, 64'h2748774cdf8eeb99, 64'h34b0bcb5e19b48a8,
        64'h391c0cb3c5c95a63, 64'h4ed8aa4ae3418acb, 64'h5b9cca4f7763e373, 64'h682e6ff3d6b2b8a3,
        64'h748f82ee5defb2fc, 64'h78a5636f43172f60, 64'h84c87814a1f0ab72, 64'h8cc702081a6439ec,
        64'h90befffa23631e28, 64'ha4506cebde82bde9, 64'hbef9a3f7b2c67915, 64'hc67178f2e372532b,
        64'hca273eceea26619c, 64'hd186b8c721c0c207, 64'heada7dd6cde0eb1e, 64'hf57d4f7fee6ed178,
        64'h06f067aa72176fba, 64'h0a637dc5a2c898a6, 64'h113f9804bef90dae, 64'h1b710b35131c471b,
        64'h28db77f523047d84, 64'h32caab7b40c72493, 64'h3c9ebe0a15c9bebc, 64'h431d67c49c100d4c,
        64'h4cc5d4becb3e42b6, 64'h597f299cfc657e2a, 64'h5fcb6fab3ad6faec, 64'h6c44198c4a475817
    };

    // 128-entry address space; everything past the last round reads zero.
    function automatic logic [KT_WIDTH-1:0] rom_word(input logic [6:0] a);
        if (a <= LAST_T) begin
            return K512[a][63 -: KT_WIDTH];
        end
        return '0;
    endfunction

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

    logic [6:0]          rom_addr [N_CH];
    logic [KT_WIDTH-1:0] rom_q    [N_CH];

    // One dual-read-port ROM per channel pair. The read register is part of
    // the channel pipeline, so it follows that channel's hold. It is not
    // reset: kt is masked by kt_valid, so its content is never visible stale.
    for (genvar p = 0; p < N_PAIR; p++) begin : g_rom
        logic [KT_WIDTH-1:0] q_a;

        always_ff @(posedge CLK) begin
            if (!hold[2*p]) begin
                q_a <= rom_word(rom_addr[2*p]);
            end
        end
        assign rom_q[2*p] = q_a;

        if (2*p + 1 < N_CH) begin : g_port_b
            logic [KT_WIDTH-1:0] q_b;

            always_ff @(posedge CLK) begin
                if (!hold[2*p+1]) begin
                    q_b <= rom_word(rom_addr[2*p+1]);
                end
            end
            assign rom_q[2*p+1] = q_b;
        end
    end

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        state_t              state, state_nx;
        logic [6:0]          cnt, cnt_nx;
        logic                issue;
        logic                drained;
        // Stage 0 tracks the ROM read register; stages 1..OUT_REGS are outputs.
        logic [OUT_REGS:0]   v_pipe, l_pipe;
        logic [6:0]          t_pipe [OUT_REGS+1];
        logic [KT_WIDTH-1:0] d_pipe [OUT_REGS];

        assign drained = v_pipe[OUT_REGS] & l_pipe[OUT_REGS];

        always_comb begin
            state_nx = state;
            cnt_nx   = cnt;
            issue    = 1'b0;
            if (clr[c]) begin
                state_nx = S_IDLE;
                cnt_nx   = '0;
            end else begin
                case (state)
                    S_IDLE: begin
                        // Accepted even under hold; the address only moves once hold drops.
                        if (start[c]) begin
                            state_nx = S_RUN;
                            cnt_nx   = '0;
                        end
                    end
                    S_RUN: begin
                        if (!hold[c]) begin
                            issue  = 1'b1;
                            cnt_nx = cnt + 7'd1;
                            if (cnt == LAST_T) begin
                                state_nx = S_DRAIN;
                                cnt_nx   = '0;
                            end
                        end
                    end
                    S_DRAIN: begin
                        if (!hold[c] && drained) begin
                            state_nx = S_IDLE;
                        end
                    end
                    default: begin
                        state_nx = S_IDLE;
                        cnt_nx   = '0;
                    end
                endcase
            end
        end

        always_ff @(posedge CLK or posedge rst) begin
            if (rst) begin
                state <= S_IDLE;
                cnt   <= '0;
            end else begin
                state <= state_nx;
                cnt   <= cnt_nx;
            end
        end

        always_ff @(posedge CLK or posedge rst) begin
            if (rst) begin
                v_pipe <= '0;
                l_pipe <= '0;
                for (int unsigned k = 0; k <= OUT_REGS; k++) begin
                    t_pipe[k] <= '0;
                end
                for (int unsigned k = 0; k < OUT_REGS; k++) begin
                    d_pipe[k] <= '0;
                end
            end else if (clr[c]) begin
                v_pipe <= '0;
                l_pipe <= '0;
            end else if (!hold[c]) begin
                v_pipe    <= {v_pipe[OUT_REGS-1:0], issue};
                l_pipe    <= {l_pipe[OUT_REGS-1:0], issue && (cnt == LAST_T)};
                t_pipe[0] <= cnt;
                for (int unsigned k = 1; k <= OUT_REGS; k++) begin
                    t_pipe[k] <= t_pipe[k-1];
                end
                d_pipe[0] <= rom_q[c];
                for (int unsigned k = 1; k < OUT_REGS; k++) begin
                    d_pipe[k] <= d_pipe[k-1];
                end
            end
        end

        assign rom_addr[c]                 = cnt;
        assign busy[c]                     = (state != S_IDLE);
        assign kt_valid[c]                 = v_pipe[OUT_REGS];
        assign kt_last[c]                  = l_pipe[OUT_REGS];
        assign kt[KT_WIDTH*c +: KT_WIDTH]  = v_pipe[OUT_REGS] ? d_pipe[OUT_REGS-1] : '0;
        assign kt_t[7*c +: 7]              = v_pipe[OUT_REGS] ? t_pipe[OUT_REGS] : '0;
    end

endmodule
